ama_riscv_mem_responder: RTL and testbench

// - Main-memory responder (consumer end) for the cache-side memory request channel.
// - Accepts one 128-bit beat request at a time: read or write, 12-bit beat address.
// - Models a fixed access latency, then returns read data on a valid/ready response channel.
// - Sits below icache/dcache (or their arbiter); replaces the flat memory model in sim and FPGA builds.

---
 rtl/ama_riscv_mem_responder.sv | 84 ++++++++
 tb/tb_ama_riscv_mem_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_mem_responder.sv
// ama_riscv_mem_responder: fixed-latency 128-bit beat memory behind the cache request channel
module ama_riscv_mem_responder #(
  parameter int    LATENCY   = 4,
  parameter int    DEPTH     = 4096,
  parameter string INIT_FILE = ""
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [11:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_last
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [11:0]   addr_q;
  logic [11:0]   req_base;
  logic [11:0]   load_addr;
  logic          load;
  logic          last_nx;
  logic          acc;
  logic          wait_done;
  logic          rsp_hs;
  logic [127:0]  mem [DEPTH];
`ifdef MEM_RESP_BURST_EN
  assign req_base = {req_addr[11:2], 2'b00};
  assign last_nx  = load_addr[1:0] == 2'b11;
`else
  assign req_base = req_addr;
  assign last_nx  = 1'b1;
`endif
  assign req_ready = (state == IDLE) && !rst;
  assign acc       = req_valid && req_ready;
  assign wait_done = cnt == CW'(LATENCY - 1);
  assign rsp_hs    = rsp_valid && rsp_ready;
  always_comb begin
    state_nx  = (state == IDLE) ? (acc ? ((LATENCY > 1) ? WAIT : (req_we ? IDLE : RESP)) : IDLE) :
                (state == WAIT) ? (wait_done ? (we_q ? IDLE : RESP) : WAIT) :
                (rsp_hs && rsp_last) ? IDLE : RESP;
    load_addr = (state == IDLE) ? req_base : addr_q;
    load      = (acc && !req_we && (LATENCY == 1)) ||
                ((state == WAIT) && wait_done && !we_q) ||
                ((state == RESP) && rsp_hs && !rsp_last);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx == WAIT) ? cnt + CW'(1) : '0;
      if (acc) we_q <= req_we;
      if (load) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem[load_addr[AW-1:0]];
        rsp_last  <= last_nx;
        addr_q    <= load_addr + 12'd1;
      end else begin
        if (acc) addr_q <= req_base;
        if (rsp_hs) begin
          rsp_valid <= 1'b0;
          rsp_last  <= 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (acc && req_we) mem[req_addr[AW-1:0]] <= req_wdata;
  end
endmodule

// File: tb/tb_ama_riscv_mem_responder.sv
// tb_ama_riscv_mem_responder: directed checks of the memory responder at LATENCY 4 and LATENCY 1.
module tb_ama_riscv_mem_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [11:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic         req_ready, rsp_valid, rsp_last;
    logic [127:0] rsp_data;
    logic         r1_valid = 1'b0, r1_we = 1'b0, s1_ready = 1'b1;
    logic [11:0]  r1_addr = '0;
    logic [127:0] r1_wdata = '0;
    logic         r1_ready, s1_valid, s1_last;
    logic [127:0] s1_data;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    ama_riscv_mem_responder #(.LATENCY(4), .DEPTH(4096)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_last(rsp_last)
    );

    ama_riscv_mem_responder #(.LATENCY(1), .DEPTH(16)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(r1_valid), .req_ready(r1_ready), .req_we(r1_we),
        .req_addr(r1_addr), .req_wdata(r1_wdata), .rsp_valid(s1_valid), .rsp_ready(s1_ready),
        .rsp_data(s1_data), .rsp_last(s1_last)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic issue(input logic we, input logic [11:0] a, input logic [127:0] d);
        int t = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!req_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("accept_timeout", 128'(t), 128'(0));
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        chk({tag, "_lat"}, 128'(n), 128'(lat));
    endtask

    // Drains one response (one beat or a whole burst) and checks the beat holding address a.
    task automatic rsp_chk(input string tag, input logic [11:0] a, input logic [127:0] exp);
`ifdef MEM_RESP_BURST_EN
        for (int b = 0; b < 4; b++) begin
            chk({tag, "_vld"}, 128'(rsp_valid), 128'(1));
            if (b == int'(a[1:0])) chk({tag, "_data"}, rsp_data, exp);
            chk({tag, "_last"}, 128'(rsp_last), 128'(b == 3));
            @(negedge clk);
        end
`else
        chk({tag, "_vld"}, 128'(rsp_valid), 128'(1));
        chk({tag, "_data"}, rsp_data, exp);
        chk({tag, "_last"}, 128'(rsp_last), 128'(1));
        @(negedge clk);
`endif
        chk({tag, "_done"}, 128'(rsp_valid), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        repeat (2) begin
            @(negedge clk);
            chk("rst_rdy", 128'(req_ready), 128'(0));
            chk("rst_vld", 128'(rsp_valid), 128'(0));
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 128'(req_ready), 128'(1));
        chk("post_rst_data", rsp_data, 128'(0));
        chk("post_rst_last", 128'(rsp_last), 128'(0));

        issue(1'b1, 12'h005, 128'hA5A5_0001);
        @(negedge clk);
        issue(1'b0, 12'h005, '0);
        wait_rsp("rd5", 4);
        rsp_chk("rd5", 12'h005, 128'hA5A5_0001);
        chk("rd5_rdy", 128'(req_ready), 128'(1));

        // Back-pressure with a read to 0x005 held pending the whole time.
        issue(1'b1, 12'h008, 128'hBEEF_0008);
        @(negedge clk);
        rsp_ready = 1'b0;
        issue(1'b0, 12'h008, '0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h005;
        wait_rsp("bp", 4);
        repeat (5) begin
            chk("bp_vld", 128'(rsp_valid), 128'(1));
            chk("bp_data", rsp_data, 128'hBEEF_0008);
            chk("bp_rdy", 128'(req_ready), 128'(0));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
`ifdef MEM_RESP_BURST_EN
        repeat (3) begin
            @(negedge clk);
            chk("bp_burst_rdy", 128'(req_ready), 128'(0));
        end
`endif
        @(negedge clk);
        chk("bp_hs_vld", 128'(rsp_valid), 128'(0));
        chk("bp_hs_rdy", 128'(req_ready), 128'(1));
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp("pend", 4);
        rsp_chk("pend", 12'h005, 128'hA5A5_0001);

        // Reset during WAIT drops the read but keeps the committed write.
        issue(1'b1, 12'h020, 128'hC0DE_0020);
        @(negedge clk);
        issue(1'b0, 12'h020, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy", 128'(req_ready), 128'(0));
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        chk("mid_rst_drop", 128'(seen), 128'(0));
        issue(1'b0, 12'h020, '0);
        wait_rsp("rd20", 4);
        rsp_chk("rd20", 12'h020, 128'hC0DE_0020);

        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 12'h010 + 12'(i), 128'h10 + 128'(i));
            @(negedge clk);
        end
        issue(1'b0, 12'h012, '0);
        wait_rsp("burst", 4);
`ifdef MEM_RESP_BURST_EN
        for (int b = 0; b < 4; b++) begin
            chk("burst_vld", 128'(rsp_valid), 128'(1));
            chk("burst_data", rsp_data, 128'h10 + 128'(b));
            chk("burst_last", 128'(rsp_last), 128'(b == 3));
            @(negedge clk);
        end
`else
        chk("single_data", rsp_data, 128'h12);
        chk("single_last", 128'(rsp_last), 128'(1));
        @(negedge clk);
`endif
        chk("burst_done", 128'(rsp_valid), 128'(0));

        // LATENCY=1, DEPTH=16: back-to-back writes, wrapped address, one-cycle read.
        r1_valid = 1'b1; r1_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r1_addr = 12'h010 + 12'(i);
            r1_wdata = 128'h100 + 128'(i);
            chk("l1_wr_rdy", 128'(r1_ready), 128'(1));
            @(negedge clk);
        end
        r1_we = 1'b0; r1_addr = 12'h003;
        @(posedge clk);
        #1 r1_valid = 1'b0;
        @(negedge clk);
        chk("l1_lat_vld", 128'(s1_valid), 128'(1));
`ifdef MEM_RESP_BURST_EN
        for (int b = 0; b < 4; b++) begin
            chk("l1_burst_data", s1_data, 128'h100 + 128'(b));
            chk("l1_burst_last", 128'(s1_last), 128'(b == 3));
            @(negedge clk);
        end
`else
        chk("l1_wrap_data", s1_data, 128'h103);
        chk("l1_last", 128'(s1_last), 128'(1));
        @(negedge clk);
`endif
        chk("l1_done", 128'(s1_valid), 128'(0));
        chk("l1_rdy", 128'(r1_ready), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
